// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU opcodes, default widths and sequencer state encoding
// for the iterative shift-add multiplier that borrows the core ALU.
package alu_mul_sequencer_pkg;

   localparam int MUL_WIDTH = 64;
   localparam int MUL_OP_W  = 4;
   localparam int MUL_CNT_W = 7;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Arbitrates the shared ALU: passes datapath requests through when idle,
// and on start runs a WIDTH x WIDTH low-half multiply by one ALU add/cycle.
// Ports: clk, rst_n (async low); start, operand_a/b (multiply request);
//   dp_operation/dp_addend1/dp_addend2 (datapath request); alu_result (in);
//   alu_operation/alu_addend1/alu_addend2 (to ALU); busy, done, product.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int OP_W  = MUL_OP_W,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [OP_W-1:0]  dp_operation,
   input  logic [WIDTH-1:0] dp_addend1,
   input  logic [WIDTH-1:0] dp_addend2,
   input  logic [WIDTH-1:0] alu_result,
   output logic [OP_W-1:0]  alu_operation,
   output logic [WIDTH-1:0] alu_addend1,
   output logic [WIDTH-1:0] alu_addend2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   mul_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CNT_W-1:0] cnt;
   logic             last;

   // Last step when no multiplier bits remain above bit 0,
   // or the full width has been consumed.
   assign last = (mplier[WIDTH-1:1] == '0) ||
                 (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      alu_operation = dp_operation;
      alu_addend1   = dp_addend1;
      alu_addend2   = dp_addend2;
      unique case (state)
         S_RUN: begin
            alu_operation = OP_W'(ALU_ADD);
            alu_addend1   = acc;
            alu_addend2   = mplier[0] ? mcand : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= operand_a;
                  mplier <= operand_b;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               acc    <= alu_result;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (last) begin
                  product <= alu_result;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
